pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the write-enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazards: load-use, control redirect from the MEM stage (branch/jal/jalr), and multi-cycle data-memory access via a ready handshake. It also detects memory timeouts, counts stall cycles, and sits beside the datapath, fed by ID-stage decode and by the ID/EX and EX/MEM register outputs.

---
 rtl/pipeline_hazard_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// It resolves load-use, MEM-stage redirects and multi-cycle data-memory
// waits, flags memory timeouts and counts cycles in which the PC is held.
module pipeline_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    id_rs1,
  input  logic [4:0]    id_rs2,
  input  logic          id_uses_rs1,
  input  logic          id_uses_rs2,
  input  logic          ex_mem_read,
  input  logic [4:0]    ex_rd,
  input  logic          mem_branch_taken,
  input  logic          mem_jal,
  input  logic          mem_jalr,
  input  logic          mem_req,
  input  logic          mem_ready,
  output logic          pc_en,
  output logic          if_id_en,
  output logic          id_ex_en,
  output logic          ex_mem_en,
  output logic          mem_wb_en,
  output logic          if_id_flush,
  output logic          id_ex_flush,
  output logic          ex_mem_flush,
  output logic          mem_busy,
  output logic          mem_error,
  output logic [CW-1:0] stall_cycles
);

  // Wide enough to hold MAX_WAIT itself; at least one bit.
  localparam int unsigned WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            mem_error_q, mem_error_d;
  logic [CW-1:0]   stall_q, stall_d;

  logic redirect;
  logic load_use;

  // Hazard detection from ID decode and the ID/EX, EX/MEM register outputs.
  always_comb begin
    redirect = mem_branch_taken | mem_jal | mem_jalr;
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

  // Next state and enable/flush outputs; freeze wins over redirect over load-use.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;

    if (!reset) begin
      // A ready cycle in MEM_WAIT is handled exactly like an unfrozen RUN cycle.
      if ((state_q == ST_RUN && !(mem_req && !mem_ready)) ||
          (state_q == ST_WAIT && mem_ready)) begin
        if (redirect) begin
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          id_ex_en     = 1'b1;
          ex_mem_en    = 1'b1;
          mem_wb_en    = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID, push one bubble into ID/EX.
          id_ex_en     = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_en    = 1'b1;
          mem_wb_en    = 1'b1;
        end else begin
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          id_ex_en     = 1'b1;
          ex_mem_en    = 1'b1;
          mem_wb_en    = 1'b1;
        end
      end

      case (state_q)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WW'(1);
          end
        end
        ST_WAIT: begin
          if (mem_ready) begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == WAIT_LIMIT) begin
            state_d    = ST_ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WW'(1);
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      endcase
    end
  end

  // Sticky error flag and saturating stall counter updates.
  always_comb begin
    mem_error_d = mem_error_q | (state_d == ST_ERROR);
    stall_d     = stall_q;
    if (!pc_en && !(&stall_q)) begin
      stall_d = stall_q + CW'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      stall_q     <= stall_d;
    end
  end

  assign mem_busy     = (state_q == ST_WAIT);
  assign mem_error    = mem_error_q;
  assign stall_cycles = stall_q;

endmodule
